i2c_slave_rx: RTL

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave delivering sub-addressed bytes with auto-increment.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       WR_VALID,
    output logic       BUSY
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA, IGNORE} state_t;
    state_t     state, state_next;
    logic [2:0] scl_q, sda_q;
    logic [3:0] cnt;
    logic [6:0] bits;
    logic       ack_on, ack_on_next, first, sda_low;
    logic       scl, scl_prev, sda, sda_prev;
    logic       scl_rise, scl_fall, start, stop, rx, ack_st, byte_done, match;
    logic [7:0] byte_val;

    assign scl       = scl_q[1];
    assign scl_prev  = scl_q[2];
    assign sda       = sda_q[1];
    assign sda_prev  = sda_q[2];
    assign scl_rise  = scl && !scl_prev;
    assign scl_fall  = !scl && scl_prev;
    assign start     = scl && scl_prev && sda_prev && !sda;
    assign stop      = scl && scl_prev && !sda_prev && sda;
    assign rx        = state == ADDR || state == SUB || state == DATA;
    assign ack_st    = state == ACK_ADDR || state == ACK_SUB || state == ACK_DATA;
    // the eighth bit is taken live from the line so a byte completes on its own edge
    assign byte_val  = {bits, sda};
    assign byte_done = rx && scl_rise && cnt == 4'd7;
    assign match     = byte_val[7:1] == SLAVE_ADDR && !byte_val[0];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state  <= IDLE;
            ack_on <= 1'b0;
        end else begin
            state  <= state_next;
            ack_on <= ack_on_next;
        end
    end

    always_comb begin
        state_next  = state;
        ack_on_next = !(start || stop) && ack_st && (scl_fall ? !ack_on : ack_on);
        if (start)
            state_next = ADDR;
        else if (stop)
            state_next = IDLE;
        else if (byte_done)
            state_next = state == ADDR ? (match ? ACK_ADDR : IGNORE) : state == SUB ? ACK_SUB : ACK_DATA;
        else if (ack_st && ack_on && scl_fall)
            state_next = state == ACK_ADDR ? SUB : DATA;
    end

    always_comb begin
        sda_low = ack_on && ack_st;
    end

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scl_q    <= 3'b111;
            sda_q    <= 3'b111;
            cnt      <= 4'd0;
            bits     <= 7'd0;
            first    <= 1'b0;
            WR_ADDR  <= 8'd0;
            WR_DATA  <= 8'd0;
            WR_VALID <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            scl_q    <= {scl_q[1:0], I2C_SCLK};
            sda_q    <= {sda_q[1:0], I2C_SDAT};
            WR_VALID <= 1'b0;
            if (start || state_next != state)
                cnt <= 4'd0;
            else if (rx && scl_rise)
                cnt <= cnt + 4'd1;
            if (rx && scl_rise)
                bits <= byte_val[6:0];
            if (stop)
                BUSY <= 1'b0;
            else if (state == ADDR && byte_done)
                BUSY <= match;
            if (state == SUB && byte_done) begin
                WR_ADDR <= byte_val;
                first   <= 1'b1;
            end
            if (state == DATA && byte_done) begin
                WR_DATA  <= byte_val;
                WR_VALID <= 1'b1;
                WR_ADDR  <= first ? WR_ADDR : WR_ADDR + 8'd1;
                first    <= 1'b0;
            end
        end
    end
endmodule
